// File: rtl/response_encoder.sv
// Serialises one response record (code, up to three args, XOR checksum) to the mbed
// over a four-phase valid/ack handshake, with per-byte timeout and whole-frame retry.
module response_encoder #(
   parameter int TIMEOUT   = 255,
   parameter int MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       resp_valid,
   output logic       resp_ready,
   input  logic [7:0] resp_code,
   input  logic [1:0] resp_nargs,
   input  logic [7:0] resp_arg1,
   input  logic [7:0] resp_arg2,
   input  logic [7:0] resp_arg3,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ack,
   output logic       busy,
   output logic       tx_error
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [1:0] {IDLE, SEND, RELEASE, GAP} state_t;

   state_t         state, state_next;
   logic [7:0]     code, arg1, arg2, arg3;
   logic [1:0]     nargs;
   logic [7:0]     chk, cur_byte, last_byte;
   logic [2:0]     byte_idx;
   logic [RW-1:0]  retry_cnt;
   logic [TW-1:0]  tmo_cnt;
   logic           timeout, last, retry_done;

   assign timeout    = (tmo_cnt == TW'(TIMEOUT - 1));
   assign last       = (byte_idx == ({1'b0, nargs} + 3'd1));
   assign retry_done = (retry_cnt == RW'(MAX_RETRY));

   // Index 0 is the code, 1..nargs the args, and anything past that the checksum.
   always_comb begin
      cur_byte = chk;
      if (byte_idx == 3'd0) begin
         cur_byte = code;
      end else if (byte_idx <= {1'b0, nargs}) begin
         case (byte_idx[1:0])
            2'd1:    cur_byte = arg1;
            2'd2:    cur_byte = arg2;
            default: cur_byte = arg3;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Ack is tested before timeout so a simultaneous ack always wins.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (resp_valid) state_next = SEND;
         SEND: begin
            if (tx_ack)       state_next = RELEASE;
            else if (timeout) state_next = GAP;
         end
         RELEASE: begin
            if (!tx_ack)      state_next = last ? IDLE : SEND;
            else if (timeout) state_next = GAP;
         end
         GAP:     state_next = retry_done ? IDLE : SEND;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      resp_ready = (state == IDLE) && !rst;
      tx_valid   = (state == SEND);
      busy       = (state != IDLE);
      tx_data    = (state == SEND) ? cur_byte : last_byte;
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && resp_valid) begin
         code  <= resp_code;
         nargs <= resp_nargs;
         arg1  <= resp_arg1;
         arg2  <= resp_arg2;
         arg3  <= resp_arg3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx  <= '0;
         chk       <= '0;
         retry_cnt <= '0;
         tmo_cnt   <= '0;
         last_byte <= '0;
         tx_error  <= 1'b0;
      end else begin
         tx_error <= (state == GAP) && retry_done;
         // Counter restarts on every state entry and only runs while waiting on the mbed.
         if (state_next == state && (state == SEND || state == RELEASE))
            tmo_cnt <= tmo_cnt + 1'b1;
         else
            tmo_cnt <= '0;
         if (state == SEND)
            last_byte <= cur_byte;
         case (state)
            IDLE: begin
               byte_idx  <= '0;
               chk       <= '0;
               retry_cnt <= '0;
            end
            SEND:    if (tx_ack) chk <= chk ^ cur_byte;
            RELEASE: if (!tx_ack && !last) byte_idx <= byte_idx + 3'd1;
            GAP: begin
               if (!retry_done) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  byte_idx  <= '0;
                  chk       <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_response_encoder.sv
// Randomised bench for response_encoder: an mbed-side responder with random ack delays,
// checked against frames built directly from code/args with an XOR checksum.
module tb_response_encoder;

   localparam int T  = 8;
   localparam int MR = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       resp_valid;
   logic       resp_ready;
   logic [7:0] resp_code;
   logic [1:0] resp_nargs;
   logic [7:0] resp_arg1, resp_arg2, resp_arg3;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ack;
   logic       busy;
   logic       tx_error;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   response_encoder #(.TIMEOUT(T), .MAX_RETRY(MR)) dut (
      .clk(clk), .rst(rst),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_code(resp_code), .resp_nargs(resp_nargs),
      .resp_arg1(resp_arg1), .resp_arg2(resp_arg2), .resp_arg3(resp_arg3),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
      .busy(busy), .tx_error(tx_error)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected frame: code, args in order, then XOR of everything before it.
   task automatic build_frame(input logic [7:0] c, input logic [1:0] n,
                              input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
      logic [7:0] args[3];
      logic [7:0] x;
      args[0] = a1; args[1] = a2; args[2] = a3;
      exp_q.delete();
      exp_q.push_back(c);
      x = c;
      for (int i = 0; i < int'(n); i++) begin
         exp_q.push_back(args[i]);
         x = x ^ args[i];
      end
      exp_q.push_back(x);
   endtask

   // Offers a record at a negedge; afterwards keeps resp_valid high with a junk record
   // that must be ignored while the frame is in progress.
   task automatic start_frame(input logic [7:0] c, input logic [1:0] n,
                              input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
      build_frame(c, n, a1, a2, a3);
      check_val("ready_before_accept", resp_ready, 1);
      resp_valid = 1'b1;
      resp_code  = c; resp_nargs = n;
      resp_arg1  = a1; resp_arg2 = a2; resp_arg3 = a3;
      @(negedge clk);
      resp_code  = ~c;
      resp_nargs = ~n;
      resp_arg1  = 8'($urandom); resp_arg2 = 8'($urandom); resp_arg3 = 8'($urandom);
      check_val("ready_after_accept", resp_ready, 0);
      check_val("busy_after_accept", busy, 1);
   endtask

   // Plays the mbed from the first cycle of byte 0 to the end of the frame.
   task automatic run_bytes(input int maxd);
      int d, r;
      for (int i = 0; i < exp_q.size(); i++) begin
         check_val("byte_valid", tx_valid, 1);
         check_val($sformatf("byte%0d_data", i), tx_data, exp_q[i]);
         d = int'($urandom_range(0, maxd));
         repeat (d) begin
            @(negedge clk);
            check_val("hold_valid", tx_valid, 1);
            check_val("hold_data", tx_data, exp_q[i]);
         end
         tx_ack = 1'b1;
         @(negedge clk);
         resp_valid = 1'b0;
         check_val("valid_drops_on_ack", tx_valid, 0);
         check_val("data_held_in_release", tx_data, exp_q[i]);
         r = int'($urandom_range(0, maxd));
         repeat (r) begin
            @(negedge clk);
            check_val("release_wait_valid", tx_valid, 0);
         end
         tx_ack = 1'b0;
         @(negedge clk);
      end
      check_val("frame_end_busy", busy, 0);
      check_val("frame_end_ready", resp_ready, 1);
      check_val("frame_end_valid", tx_valid, 0);
      check_val("frame_end_no_error", tx_error, 0);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) begin
         @(negedge clk);
         check_val("rst_valid", tx_valid, 0);
         check_val("rst_data", tx_data, 0);
         check_val("rst_busy", busy, 0);
         check_val("rst_error", tx_error, 0);
         check_val("rst_ready_low", resp_ready, 0);
      end
      rst = 1'b0;
      @(negedge clk);
      check_val("ready_after_rst", resp_ready, 1);
      check_val("error_after_rst", tx_error, 0);
   endtask

   initial begin
      rst = 1'b1; resp_valid = 1'b0; tx_ack = 1'b0;
      resp_code = '0; resp_nargs = '0; resp_arg1 = '0; resp_arg2 = '0; resp_arg3 = '0;
      do_reset(2);

      // Short and full frames with an immediate responder.
      start_frame(8'h05, 2'd0, 8'h00, 8'h00, 8'h00);
      run_bytes(0);
      check_val("short_last_byte", exp_q[1], 8'h05);
      start_frame(8'h04, 2'd3, 8'h12, 8'h34, 8'h56);
      run_bytes(2);
      check_val("full_checksum_byte", tx_data, 8'h74);

      // Ack asserted while idle must not start anything.
      tx_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_val("idle_ack_busy", busy, 0);
         check_val("idle_ack_valid", tx_valid, 0);
      end
      tx_ack = 1'b0;
      @(negedge clk);

      // Reset while idle clears the held tx_data (last value was 0x74).
      do_reset(2);

      // No ack: three attempts of T cycles each, one-cycle gaps, then a single error pulse.
      start_frame(8'h04, 2'd3, 8'h12, 8'h34, 8'h56);
      resp_valid = 1'b0;
      for (int a = 0; a <= MR; a++) begin
         for (int k = 0; k < T; k++) begin
            check_val("noack_valid", tx_valid, 1);
            check_val("noack_data", tx_data, 8'h04);
            @(negedge clk);
         end
         check_val("noack_gap_valid", tx_valid, 0);
         check_val("noack_gap_busy", busy, 1);
         check_val("noack_gap_noerr", tx_error, 0);
         @(negedge clk);
      end
      check_val("noack_error_pulse", tx_error, 1);
      check_val("noack_ready", resp_ready, 1);
      check_val("noack_busy", busy, 0);
      @(negedge clk);
      check_val("noack_error_single", tx_error, 0);

      // Stuck ack in RELEASE times out, frame restarts at byte 0 and then completes.
      start_frame(8'h04, 2'd3, 8'h12, 8'h34, 8'h56);
      resp_valid = 1'b0;
      check_val("stuck_byte0", tx_data, 8'h04);
      tx_ack = 1'b1;
      for (int k = 0; k < T; k++) begin
         @(negedge clk);
         check_val("stuck_release_valid", tx_valid, 0);
      end
      @(negedge clk);
      check_val("stuck_gap_valid", tx_valid, 0);
      check_val("stuck_gap_busy", busy, 1);
      tx_ack = 1'b0;
      @(negedge clk);
      run_bytes(3);

      // Ack exactly on the last allowed SEND cycle wins over the timeout.
      start_frame(8'h3C, 2'd1, 8'hA5, 8'h00, 8'h00);
      resp_valid = 1'b0;
      repeat (T - 1) begin
         check_val("late_ack_valid", tx_valid, 1);
         @(negedge clk);
      end
      check_val("late_ack_data", tx_data, 8'h3C);
      exp_q.pop_front();
      tx_ack = 1'b1;
      @(negedge clk);
      check_val("late_ack_release", tx_valid, 0);
      tx_ack = 1'b0;
      @(negedge clk);
      run_bytes(1);

      // Reset mid-frame after byte 1 was acknowledged: no error, next frame is clean.
      start_frame(8'h11, 2'd3, 8'h22, 8'h33, 8'h44);
      resp_valid = 1'b0;
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      @(negedge clk);
      check_val("midrst_byte1", tx_data, 8'h22);
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      do_reset(1);
      start_frame(8'h03, 2'd1, 8'h0F, 8'h00, 8'h00);
      check_val("midrst_checksum_model", exp_q[2], 8'h0C);
      run_bytes(2);

      // Random frames with random responder delays up to the boundary.
      for (int f = 0; f < 25; f++) begin
         start_frame(8'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         run_bytes(T - 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
